gestor_acesso_parametrizado: RTL and testbench

Parametrised gate-access controller for the parking entrance. It replaces the single-slot entry FSM with one that adds the following:
- internal occupancy counter with configurable capacity;
- cycle-based timeouts for password entry and vehicle passage;
- password-attempt limit with a timed lockout.
It sits between the gate sensors and password panel on one side and the gate, display, lights and panel enables on the other.

---
 rtl/acesso_pkg.sv | 30 +++
 rtl/contador_vagas.sv | 43 ++++
 rtl/gestor_acesso_parametrizado.sv | 156 +++++++++++++++
 tb/tb_gestor_acesso_parametrizado.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/acesso_pkg.sv
// ---------------------------------------------------------------------------
// acesso_pkg
// Shared definitions for the parking-entrance access controller:
//   - estado_t   : FSM state encoding (3 bits)
//   - *_PADRAO   : default values for the controller parameters
//   - max3       : helper used to size the shared timer
// ---------------------------------------------------------------------------
package acesso_pkg;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        INSERIR_SENHA = 3'd1,
        ENTRADA       = 3'd2,
        CHEIO         = 3'd3,
        BLOQUEIO      = 3'd4
    } estado_t;

    localparam int CAPACIDADE_PADRAO      = 16;
    localparam int TIMEOUT_SENHA_PADRAO   = 20;
    localparam int TIMEOUT_ENTRADA_PADRAO = 20;
    localparam int MAX_TENTATIVAS_PADRAO  = 3;
    localparam int BLOQUEIO_CICLOS_PADRAO = 30;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/contador_vagas.sv
// ---------------------------------------------------------------------------
// contador_vagas
// Saturating up/down occupancy counter, range 0..CAPACIDADE.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset, clears the count
//   inc_i    : one vehicle entered
//   dec_i    : one vehicle left
//   vagas_o  : current occupancy (counter register)
// ---------------------------------------------------------------------------
module contador_vagas
    import acesso_pkg::*;
#(
    parameter int CAPACIDADE = CAPACIDADE_PADRAO,
    parameter int LARG       = $clog2(CAPACIDADE_PADRAO + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [LARG-1:0] vagas_o
);

    logic [LARG-1:0] vagas_q, vagas_d;

    always_comb begin
        vagas_d = vagas_q;
        // Simultaneous entry and exit cancel out; otherwise clamp at both ends.
        if (inc_i && !dec_i) begin
            if (vagas_q != LARG'(CAPACIDADE)) vagas_d = vagas_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (vagas_q != '0) vagas_d = vagas_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) vagas_q <= '0;
        else       vagas_q <= vagas_d;
    end

    assign vagas_o = vagas_q;

endmodule

// File: rtl/gestor_acesso_parametrizado.sv
// ---------------------------------------------------------------------------
// gestor_acesso_parametrizado
// Gate-access controller for the parking entrance: password entry with
// attempt limit and timed lockout, timed vehicle passage, and an internal
// occupancy counter that blocks entry when the lot is full.
// Ports:
//   clk, rst (sync, active-high)
//   SENSOR_EXTERNO  : vehicle at outer sensor (level)
//   SENSOR_INTERNO  : vehicle crossed inner sensor (level)
//   SENSOR_SAIDA    : one-cycle pulse per exiting vehicle
//   SENHA_VALIDA / SENHA_INVALIDA : one-cycle panel results
//   STATUS_*        : Moore decode of the state register
//   VAGAS_OCUPADAS  : current occupancy
// ---------------------------------------------------------------------------
module gestor_acesso_parametrizado
    import acesso_pkg::*;
#(
    parameter int CAPACIDADE      = CAPACIDADE_PADRAO,
    parameter int TIMEOUT_SENHA   = TIMEOUT_SENHA_PADRAO,
    parameter int TIMEOUT_ENTRADA = TIMEOUT_ENTRADA_PADRAO,
    parameter int MAX_TENTATIVAS  = MAX_TENTATIVAS_PADRAO,
    parameter int BLOQUEIO_CICLOS = BLOQUEIO_CICLOS_PADRAO,
    localparam int LARG_VAGAS     = $clog2(CAPACIDADE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SENSOR_EXTERNO,
    input  logic                  SENSOR_INTERNO,
    input  logic                  SENSOR_SAIDA,
    input  logic                  SENHA_VALIDA,
    input  logic                  SENHA_INVALIDA,
    output logic                  STATUS_DA_CANCELA_DO_ESTACIONAMENTO,
    output logic                  STATUS_DO_DISPLAY,
    output logic                  STATUS_DA_SINALIZACAO_DE_LUZES,
    output logic                  STATUS_DO_PAINEL_DE_SENHA,
    output logic                  STATUS_DO_ESTACIONAMENTO_CHEIO,
    output logic                  STATUS_DE_BLOQUEIO,
    output logic [LARG_VAGAS-1:0] VAGAS_OCUPADAS
);

    // One timer serves every timed state, so size it for the longest one.
    localparam int TIMER_W = $clog2(max3(TIMEOUT_SENHA, TIMEOUT_ENTRADA, BLOQUEIO_CICLOS) + 1);
    localparam int TENT_W  = $clog2(MAX_TENTATIVAS + 1);

    estado_t              estado_q, estado_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TENT_W-1:0]    tent_q, tent_d;
    logic                 nova_tentativa;
    logic                 inc_vaga;
    logic [LARG_VAGAS-1:0] vagas;

    contador_vagas #(
        .CAPACIDADE (CAPACIDADE),
        .LARG       (LARG_VAGAS)
    ) u_contador (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (inc_vaga),
        .dec_i   (SENSOR_SAIDA),
        .vagas_o (vagas)
    );

    assign VAGAS_OCUPADAS = vagas;

    always_comb begin
        estado_d       = estado_q;
        tent_d         = tent_q;
        nova_tentativa = 1'b0;
        inc_vaga       = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (vagas == LARG_VAGAS'(CAPACIDADE)) estado_d = CHEIO;
                else if (SENSOR_EXTERNO)              estado_d = INSERIR_SENHA;
            end
            INSERIR_SENHA: begin
                // An invalid result wins even if the panel also flagged valid.
                if (SENHA_INVALIDA) begin
                    if (int'(tent_q) + 1 == MAX_TENTATIVAS) begin
                        estado_d = BLOQUEIO;
                    end else begin
                        tent_d         = tent_q + 1'b1;
                        nova_tentativa = 1'b1;
                    end
                end else if (SENHA_VALIDA) begin
                    estado_d = ENTRADA;
                end else if (timer_q == TIMER_W'(TIMEOUT_SENHA - 1)) begin
                    estado_d = OCIOSO;
                end
            end
            ENTRADA: begin
                if (SENSOR_INTERNO) begin
                    estado_d = OCIOSO;
                    inc_vaga = 1'b1;
                end else if (timer_q == TIMER_W'(TIMEOUT_ENTRADA - 1)) begin
                    estado_d = OCIOSO;
                end
            end
            CHEIO: begin
                if (vagas < LARG_VAGAS'(CAPACIDADE)) estado_d = OCIOSO;
            end
            BLOQUEIO: begin
                if (timer_q == TIMER_W'(BLOQUEIO_CICLOS - 1)) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        if (estado_q == INSERIR_SENHA && estado_d != INSERIR_SENHA) tent_d = '0;

        // A retry restarts the password window just like entering the state.
        if (estado_d != estado_q || nova_tentativa) timer_d = '0;
        else                                        timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
            tent_q   <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            tent_q   <= tent_d;
        end
    end

    always_comb begin
        STATUS_DA_CANCELA_DO_ESTACIONAMENTO = 1'b0;
        STATUS_DO_DISPLAY                   = 1'b0;
        STATUS_DA_SINALIZACAO_DE_LUZES      = 1'b0;
        STATUS_DO_PAINEL_DE_SENHA           = 1'b0;
        STATUS_DO_ESTACIONAMENTO_CHEIO      = 1'b0;
        STATUS_DE_BLOQUEIO                  = 1'b0;
        case (estado_q)
            INSERIR_SENHA: begin
                STATUS_DO_DISPLAY         = 1'b1;
                STATUS_DO_PAINEL_DE_SENHA = 1'b1;
            end
            ENTRADA: begin
                STATUS_DA_CANCELA_DO_ESTACIONAMENTO = 1'b1;
                STATUS_DO_DISPLAY                   = 1'b1;
                STATUS_DA_SINALIZACAO_DE_LUZES      = 1'b1;
            end
            CHEIO: begin
                STATUS_DO_DISPLAY              = 1'b1;
                STATUS_DO_ESTACIONAMENTO_CHEIO = 1'b1;
            end
            BLOQUEIO: begin
                STATUS_DO_DISPLAY  = 1'b1;
                STATUS_DE_BLOQUEIO = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gestor_acesso_parametrizado.sv
module tb_gestor_acesso_parametrizado;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext, inn, sai, val, inv;
    logic       o_cancela, o_display, o_luzes, o_painel, o_cheio, o_bloq;
    logic [4:0] vagas;

    always #5 clk = ~clk;

    gestor_acesso_parametrizado dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .SENSOR_EXTERNO                      (ext),
        .SENSOR_INTERNO                      (inn),
        .SENSOR_SAIDA                        (sai),
        .SENHA_VALIDA                        (val),
        .SENHA_INVALIDA                      (inv),
        .STATUS_DA_CANCELA_DO_ESTACIONAMENTO (o_cancela),
        .STATUS_DO_DISPLAY                   (o_display),
        .STATUS_DA_SINALIZACAO_DE_LUZES      (o_luzes),
        .STATUS_DO_PAINEL_DE_SENHA           (o_painel),
        .STATUS_DO_ESTACIONAMENTO_CHEIO      (o_cheio),
        .STATUS_DE_BLOQUEIO                  (o_bloq),
        .VAGAS_OCUPADAS                      (vagas)
    );

    // Output pattern {cancela, display, luzes, painel, cheio, bloqueio}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_SENHA = 6'b010100;
    localparam logic [5:0] O_ENT   = 6'b111000;
    localparam logic [5:0] O_CHEIO = 6'b010010;
    localparam logic [5:0] O_BLOQ  = 6'b010001;

    typedef struct packed {
        logic [5:0] o;
        logic [4:0] v;
    } exp_t;

    typedef struct packed {
        logic       r, e, i, s, va, iv;
        logic [5:0] o;
        logic [4:0] v;
    } vec_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic cyc(input string nome, input logic r, input logic e, input logic i,
                       input logic s, input logic va, input logic iv,
                       input logic [5:0] eo, input logic [4:0] ev);
        exp_t ex;
        logic [5:0] got;
        rst = r; ext = e; inn = i; sai = s; val = va; inv = iv;
        sb.push_back('{o: eo, v: ev});
        @(posedge clk);
        #1;
        got = {o_cancela, o_display, o_luzes, o_painel, o_cheio, o_bloq};
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", nome);
        end else begin
            ex = sb.pop_front();
            if (got !== ex.o || vagas !== ex.v) begin
                n_fail++;
                $display("FAIL %s: got out=%b vagas=%0d, expected out=%b vagas=%0d",
                         nome, got, vagas, ex.o, ex.v);
            end
        end
    endtask

    task automatic idle(input string nome, input logic [5:0] eo, input logic [4:0] ev);
        cyc(nome, 0, 0, 0, 0, 0, 0, eo, ev);
    endtask

    task automatic entrada_completa(input logic [4:0] k);
        cyc("ent_ext", 0, 1, 0, 0, 0, 0, O_SENHA, k);
        cyc("ent_val", 0, 0, 0, 0, 1, 0, O_ENT, k);
        cyc("ent_int", 0, 0, 1, 0, 0, 0, O_IDLE, k + 5'd1);
    endtask

    vec_t tab[15];

    initial begin
        rst = 1'b1; ext = 0; inn = 0; sai = 0; val = 0; inv = 0;

        // r  e  i  s  va iv  out      vagas
        tab[0]  = '{1, 0, 0, 0, 0, 0, O_IDLE,  5'd0};
        tab[1]  = '{1, 1, 0, 0, 0, 0, O_IDLE,  5'd0};
        tab[2]  = '{0, 1, 0, 0, 0, 0, O_SENHA, 5'd0};
        tab[3]  = '{0, 0, 0, 0, 0, 0, O_SENHA, 5'd0};
        tab[4]  = '{0, 0, 0, 0, 0, 0, O_SENHA, 5'd0};
        tab[5]  = '{0, 0, 0, 0, 1, 0, O_ENT,   5'd0};
        tab[6]  = '{0, 0, 0, 0, 0, 0, O_ENT,   5'd0};
        tab[7]  = '{0, 0, 1, 0, 0, 0, O_IDLE,  5'd1};
        tab[8]  = '{0, 0, 0, 0, 0, 0, O_IDLE,  5'd1};
        tab[9]  = '{0, 1, 0, 0, 0, 0, O_SENHA, 5'd1};
        tab[10] = '{0, 0, 0, 0, 1, 1, O_SENHA, 5'd1};
        tab[11] = '{0, 0, 0, 0, 1, 0, O_ENT,   5'd1};
        tab[12] = '{0, 0, 1, 1, 0, 0, O_IDLE,  5'd1};
        tab[13] = '{0, 0, 0, 1, 0, 0, O_IDLE,  5'd0};
        tab[14] = '{0, 0, 0, 1, 0, 0, O_IDLE,  5'd0};

        for (int k = 0; k < 15; k++) begin
            cyc($sformatf("tab%0d", k), tab[k].r, tab[k].e, tab[k].i, tab[k].s,
                tab[k].va, tab[k].iv, tab[k].o, tab[k].v);
        end

        // Password timeout: exactly 20 cycles with the panel enabled.
        cyc("tmo_senha_in", 0, 1, 0, 0, 0, 0, O_SENHA, 5'd0);
        for (int k = 1; k < 20; k++) idle($sformatf("tmo_senha_%0d", k), O_SENHA, 5'd0);
        idle("tmo_senha_out", O_IDLE, 5'd0);

        // Passage timeout: 20 cycles of open gate, no occupancy change.
        cyc("tmo_ent_ext", 0, 1, 0, 0, 0, 0, O_SENHA, 5'd0);
        cyc("tmo_ent_val", 0, 0, 0, 0, 1, 0, O_ENT, 5'd0);
        for (int k = 1; k < 20; k++) idle($sformatf("tmo_ent_%0d", k), O_ENT, 5'd0);
        idle("tmo_ent_out", O_IDLE, 5'd0);

        // Three invalid passwords, then 30 cycles of lockout ignoring the panel.
        cyc("bloq_ext",  0, 1, 0, 0, 0, 0, O_SENHA, 5'd0);
        cyc("bloq_inv1", 0, 0, 0, 0, 0, 1, O_SENHA, 5'd0);
        cyc("bloq_inv2", 0, 0, 0, 0, 0, 1, O_SENHA, 5'd0);
        cyc("bloq_inv3", 0, 0, 0, 0, 0, 1, O_BLOQ,  5'd0);
        for (int k = 1; k < 30; k++) begin
            if (k % 7 == 3) cyc($sformatf("bloq_val_%0d", k), 0, 0, 0, 0, 1, 0, O_BLOQ, 5'd0);
            else            idle($sformatf("bloq_%0d", k), O_BLOQ, 5'd0);
        end
        idle("bloq_out", O_IDLE, 5'd0);

        // Attempt counter must have cleared: two invalids do not lock.
        cyc("tent_ext",  0, 1, 0, 0, 0, 0, O_SENHA, 5'd0);
        cyc("tent_inv1", 0, 0, 0, 0, 0, 1, O_SENHA, 5'd0);
        cyc("tent_inv2", 0, 0, 0, 0, 0, 1, O_SENHA, 5'd0);
        cyc("tent_val",  0, 0, 0, 0, 1, 0, O_ENT,   5'd0);
        cyc("tent_int",  0, 0, 1, 0, 0, 0, O_IDLE,  5'd1);

        // Fill the lot: 15 more entries reach capacity.
        for (int k = 1; k < 16; k++) entrada_completa(5'(k));
        cyc("cheio_in",   0, 1, 0, 0, 0, 0, O_CHEIO, 5'd16);
        cyc("cheio_ext",  0, 1, 0, 0, 0, 0, O_CHEIO, 5'd16);
        cyc("cheio_sai",  0, 0, 0, 1, 0, 0, O_CHEIO, 5'd15);
        idle("cheio_out", O_IDLE, 5'd15);

        // Reset while the gate is open with 5 vehicles inside.
        cyc("rst_pre", 1, 0, 0, 0, 0, 0, O_IDLE, 5'd0);
        for (int k = 0; k < 5; k++) entrada_completa(5'(k));
        cyc("rst_ext", 0, 1, 0, 0, 0, 0, O_SENHA, 5'd5);
        cyc("rst_val", 0, 0, 0, 0, 1, 0, O_ENT,   5'd5);
        cyc("rst_mid", 1, 0, 0, 0, 0, 0, O_IDLE,  5'd0);
        idle("rst_after", O_IDLE, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
